// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional feature macro: BIN2BCD_SIGNED_EN (two's-complement input, 4'hA sign digit).
`default_nettype none

module bin2bcd_seq #(
  parameter int          BIN_W   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [BIN_W-1:0]   shreg_q,   shreg_d;
  logic [15:0]        scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               range_q,   range_d;
  logic               neg_q,     neg_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [15:0]        bcd_q,     bcd_d;
  logic               ovf_q,     ovf_d;

  logic [BIN_W-1:0]   w_mag;
  logic               w_neg;
  logic               w_range;
  logic [15:0]        w_scratch_adj;
  logic [15:0]        w_scratch_shift;
  logic [BIN_W-1:0]   w_shreg_shift;

`ifdef BIN2BCD_SIGNED_EN
  logic [BIN_W:0]     w_mag_wide;

  // Magnitude is formed one bit wider so the most negative input stays exact.
  always_comb begin
    w_neg      = bin_in[BIN_W-1];
    w_mag_wide = {1'b0, bin_in};
    if (w_neg) begin
      w_mag_wide = -{bin_in[BIN_W-1], bin_in};
    end
    w_mag   = w_mag_wide[BIN_W-1:0];
    w_range = w_neg ? (32'(w_mag_wide) > 32'd999) : (32'(bin_in) > MAX_VAL);
  end
`else
  always_comb begin
    w_neg   = 1'b0;
    w_mag   = bin_in;
    w_range = 32'(bin_in) > MAX_VAL;
  end
`endif

  always_comb begin
    w_scratch_adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        w_scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    // Carry out of the top nibble is dropped; such values are overflow anyway.
    w_scratch_shift = {w_scratch_adj[14:0], shreg_q[BIN_W-1]};
    w_shreg_shift   = {shreg_q[BIN_W-2:0], 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    range_d   = range_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d   = w_mag;
          scratch_d = 16'h0000;
          cnt_d     = CNT_W'(BIN_W);
          range_d   = w_range;
          neg_d     = w_neg;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = w_scratch_shift;
        shreg_d   = w_shreg_shift;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (range_q) begin
            bcd_d = 16'hFFFF;
            ovf_d = 1'b1;
          end else begin
            bcd_d = neg_q ? {4'hA, w_scratch_shift[11:0]} : w_scratch_shift;
            ovf_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      scratch_q <= 16'h0000;
      cnt_q     <= '0;
      range_q   <= 1'b0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= 16'h0000;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      range_q   <= range_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (expected words queued at start, checked at done).
`default_nettype none

module tb_bin2bcd_seq;
  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [15:0]      bcd_out;
  logic             ovf;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  logic [16:0] sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  bin2bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  // Reference: decimal digits by division, {ovf, bcd}.
  function automatic logic [16:0] model(input logic [BIN_W-1:0] b);
    int v;
    bit neg;
    logic [15:0] d;
    v = int'(b);
    neg = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (b[BIN_W-1]) begin
      neg = 1'b1;
      v = (1 << BIN_W) - v;
    end
`endif
    if ((!neg && v > 9999) || (neg && v > 999)) return {1'b1, 16'hFFFF};
    d = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    if (neg) d[15:12] = 4'hA;
    return {1'b0, d};
  endfunction

  task automatic start_conv(input logic [BIN_W-1:0] v);
    bin_in = v;
    start  = 1'b1;
    sb_q.push_back(model(v));
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bin_in = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    if (bcd_out !== 16'h0000) begin errors++; $display("FAIL reset_bcd got=%h exp=0000", bcd_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero;
    int cyc;
    logic [16:0] e;
    start_conv('0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_c1 got=%b exp=1", busy); end
    wait_done(cyc);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL zero_timeout got=no_done exp=done");
      sb_q.delete();
    end else begin
      e = sb_q.pop_front();
      checks += 4;
      if (cyc !== 15) begin errors++; $display("FAIL zero_latency got=%0d exp=15", cyc); end
      if (bcd_out !== 16'h0000) begin errors++; $display("FAIL zero_bcd got=%h exp=0000", bcd_out); end
      if (ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf got=%b exp=0", ovf); end
      if ({ovf, bcd_out} !== e) begin errors++; $display("FAIL zero_sb got=%h exp=%h", {ovf, bcd_out}, e); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL zero_after got=done%b_busy%b exp=done0_busy0", done, busy);
      end
    end
  endtask

  task automatic test_values;
    logic [BIN_W-1:0] vals[7];
    int cyc;
    logic [16:0] e;
    vals[0] = BIN_W'(1234);
    vals[1] = BIN_W'(9999);
    vals[2] = BIN_W'(10000);
    vals[3] = BIN_W'(8191);
    vals[4] = BIN_W'($urandom_range(16383));
    vals[5] = BIN_W'($urandom_range(9999));
    vals[6] = BIN_W'(16383);
    foreach (vals[i]) begin
      start_conv(vals[i]);
      wait_done(cyc);
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL val_timeout in=%0d got=no_done exp=done", vals[i]);
        sb_q.delete();
      end else begin
        e = sb_q.pop_front();
        if ({ovf, bcd_out} !== e) begin
          errors++; $display("FAIL val_result in=%0d got=%b_%h exp=%b_%h", vals[i], ovf, bcd_out, e[16], e[15:0]);
        end
        if (i == 0) begin
          checks++;
          if ({ovf, bcd_out} !== {1'b0, 16'h1234}) begin
            errors++; $display("FAIL val_1234 got=%b_%h exp=0_1234", ovf, bcd_out);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_held;
    int nb, nd;
    logic [15:0] got;
    logic [16:0] e;
    nb = 0; nd = 0; got = '0;
    bin_in = BIN_W'(42);
    start  = 1'b1;
    sb_q.push_back(model(BIN_W'(42)));
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bin_in = BIN_W'(77);
      if (c == 3) start = 1'b0;
      if (busy === 1'b1) nb++;
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) got = bcd_out;
      end
    end
    e = sb_q.pop_front();
    checks += 4;
    if (nb !== 15) begin errors++; $display("FAIL held_busy_cycles got=%0d exp=15", nb); end
    if (nd !== 1) begin errors++; $display("FAIL held_done_count got=%0d exp=1", nd); end
    if (got !== 16'h0042) begin errors++; $display("FAIL held_result got=%h exp=0042", got); end
    if (got !== e[15:0]) begin errors++; $display("FAIL held_sb got=%h exp=%h", got, e[15:0]); end
  endtask

  task automatic test_abort;
    int cyc, nd;
    start_conv(BIN_W'(321));
    wait_done(cyc);
    checks++;
    if (done !== 1'b1 || bcd_out !== 16'h0321) begin
      errors++; $display("FAIL abort_prior got=%h exp=0321", bcd_out);
    end
    sb_q.delete();
    @(negedge clk);
    start_conv(BIN_W'(5678));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    checks += 3;
    if (bcd_out !== 16'h0000) begin errors++; $display("FAIL abort_bcd got=%h exp=0000", bcd_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf got=%b exp=0", ovf); end
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
  endtask

  task automatic test_back_to_back;
    int t[3];
    int n, nd;
    logic [16:0] e;
    bin_in = BIN_W'(1);
    start  = 1'b1;
    sb_q.push_back(model(BIN_W'(1)));
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      t[k] = cyc_cnt;
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL b2b_timeout idx=%0d got=no_done exp=done", k);
        sb_q.delete();
        start = 1'b0;
        break;
      end
      e = sb_q.pop_front();
      if ({ovf, bcd_out} !== e || bcd_out !== 16'(k + 1)) begin
        errors++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", k, bcd_out, 16'(k + 1));
      end
      if (k < 2) begin
        bin_in = BIN_W'(k + 2);
        sb_q.push_back(model(BIN_W'(k + 2)));
      end else begin
        start = 1'b0;
      end
      if (k > 0) begin
        checks++;
        if (t[k] - t[k-1] !== 16) begin
          errors++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=16", k, t[k] - t[k-1]);
        end
      end
    end
    start = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL b2b_extra_done got=%0d exp=0", nd); end
    sb_q.delete();
  endtask

`ifdef BIN2BCD_SIGNED_EN
  task automatic test_signed;
    logic [BIN_W-1:0] vals[3];
    logic [16:0] exp_lit[3];
    int cyc;
    logic [16:0] e;
    vals[0] = BIN_W'(-42);   exp_lit[0] = {1'b0, 16'hA042};
    vals[1] = BIN_W'(-1000); exp_lit[1] = {1'b1, 16'hFFFF};
    vals[2] = BIN_W'(-8192); exp_lit[2] = {1'b1, 16'hFFFF};
    foreach (vals[i]) begin
      start_conv(vals[i]);
      wait_done(cyc);
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL signed_timeout idx=%0d got=no_done exp=done", i);
        sb_q.delete();
      end else begin
        e = sb_q.pop_front();
        if ({ovf, bcd_out} !== exp_lit[i] || e !== exp_lit[i]) begin
          errors++; $display("FAIL signed_result idx=%0d got=%b_%h exp=%b_%h", i, ovf, bcd_out, exp_lit[i][16], exp_lit[i][15:0]);
        end
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; bin_in = '0;
    test_reset();
    test_zero();
    test_values();
    test_start_held();
    test_abort();
    test_back_to_back();
`ifdef BIN2BCD_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
